// File: rtl/mem_arbiter.sv
// Purpose : shares one synchronous memory port between a VGA scanout master
//           (absolute priority, zero added latency) and two generic requesters
//           (CPU, DMA) served round-robin through an IDLE -> ISSUE -> ACK FSM.
// Latency : generic req-to-ack 2 cycles minimum, one generic access per 3
//           cycles; VGA cs/addr reach memory combinationally.
// Backpressure: requesters hold req until their one-cycle ack; VGA may claim
//           the next cycle (i_vga_access) or steal an ISSUE cycle (i_vga_cs),
//           in which case the generic access is dropped and retried.
//
// Ports:
//   i_clk, i_reset                       clock, async active-high reset
//   i_vga_addr/i_vga_cs/i_vga_access     VGA master (read only)
//   o_vga_dat                            VGA read data (= i_mem_dat)
//   i_{cpu,dma}_req/addr/dat/we          generic requester request bundle
//   o_{cpu,dma}_ack/dat                  completion pulse and read data
//   o_mem_addr/dat/we/cs, i_mem_dat      memory port
//   o_conflict                           sticky VGA-vs-generic collision flag

module mem_arbiter (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic [15:0] i_vga_addr,
    input  logic        i_vga_cs,
    input  logic        i_vga_access,
    output logic [7:0]  o_vga_dat,

    input  logic        i_cpu_req,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_dat,
    input  logic        i_cpu_we,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_dat,

    input  logic        i_dma_req,
    input  logic [15:0] i_dma_addr,
    input  logic [7:0]  i_dma_dat,
    input  logic        i_dma_we,
    output logic        o_dma_ack,
    output logic [7:0]  o_dma_dat,

    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_dat,
    output logic        o_mem_we,
    output logic        o_mem_cs,
    input  logic [7:0]  i_mem_dat,

    output logic        o_conflict
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    // Requester identity, used for the grant owner and the round-robin pointer.
    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DMA = 1'b1;

    state_e      state_q,    state_d;
    logic        owner_q,    owner_d;
    logic [15:0] addr_q,     addr_d;
    logic [7:0]  dat_q,      dat_d;
    logic        we_q,       we_d;
    logic        ptr_q,      ptr_d;
    logic        reserved_q, reserved_d;
    logic        conflict_q, conflict_d;
    logic        cpu_ack_q,  cpu_ack_d;
    logic        dma_ack_q,  dma_ack_d;

    logic        any_req;
    logic        winner;
    logic        vga_yield;
    logic        generic_owns;

    // ------------------------------------------------------------------
    // Winner selection: a lone requester wins outright; when both ask, the
    // round-robin pointer breaks the tie.
    // ------------------------------------------------------------------
    always_comb begin
        any_req = i_cpu_req | i_dma_req;
        winner  = SEL_CPU;
        if (i_cpu_req && i_dma_req) begin
            winner = ptr_q;
        end else if (i_dma_req) begin
            winner = SEL_DMA;
        end
    end

    // VGA takes the port during ISSUE if it drives cs now, or if the cycle was
    // reserved one cycle earlier. The reservation case cannot normally occur
    // because IDLE only issues when i_vga_access is low, but honouring it keeps
    // VGA safe against any path that lands in ISSUE on a reserved cycle.
    assign vga_yield    = i_vga_cs | reserved_q;
    assign generic_owns = (state_q == ST_ISSUE) && !vga_yield;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        ptr_d      = ptr_q;
        conflict_d = conflict_q;
        reserved_d = i_vga_access;
        cpu_ack_d  = 1'b0;
        dma_ack_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req && !i_vga_access) begin
                    state_d = ST_ISSUE;
                    owner_d = winner;
                    if (winner == SEL_DMA) begin
                        addr_d = i_dma_addr;
                        dat_d  = i_dma_dat;
                        we_d   = i_dma_we;
                    end else begin
                        addr_d = i_cpu_addr;
                        dat_d  = i_cpu_dat;
                        we_d   = i_cpu_we;
                    end
                end
            end

            ST_ISSUE: begin
                if (vga_yield) begin
                    // Access lost to VGA: no ack, pointer untouched so the
                    // same requester wins the retry.
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_ACK;
                    cpu_ack_d = (owner_q == SEL_CPU);
                    dma_ack_d = (owner_q == SEL_DMA);
                end
                if (i_vga_cs) begin
                    conflict_d = 1'b1;
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
                // Point away from the requester just served.
                ptr_d   = ~owner_q;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= SEL_CPU;
            addr_q     <= 16'h0000;
            dat_q      <= 8'h00;
            we_q       <= 1'b0;
            ptr_q      <= SEL_CPU;
            reserved_q <= 1'b0;
            conflict_q <= 1'b0;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            ptr_q      <= ptr_d;
            reserved_q <= reserved_d;
            conflict_q <= conflict_d;
            cpu_ack_q  <= cpu_ack_d;
            dma_ack_q  <= dma_ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory port mux: the generic latch drives memory only in an ISSUE
    // cycle that VGA did not take; otherwise VGA passes straight through.
    // ------------------------------------------------------------------
    always_comb begin
        if (generic_owns) begin
            o_mem_cs   = 1'b1;
            o_mem_addr = addr_q;
            o_mem_dat  = dat_q;
            o_mem_we   = we_q;
        end else begin
            o_mem_cs   = i_vga_cs;
            o_mem_addr = i_vga_addr;
            o_mem_dat  = 8'h00;
            o_mem_we   = 1'b0;
        end
    end

    // Read data: memory returns data the cycle after cs, which is the ACK
    // cycle for generic accesses and needs no extra staging.
    assign o_vga_dat  = i_mem_dat;
    assign o_cpu_ack  = cpu_ack_q;
    assign o_dma_ack  = dma_ack_q;
    assign o_cpu_dat  = cpu_ack_q ? i_mem_dat : 8'h00;
    assign o_dma_dat  = dma_ack_q ? i_mem_dat : 8'h00;
    assign o_conflict = conflict_q;

endmodule
